// File: rtl/instruction_memory_loader_pkg.sv
// ---------------------------------------------------------------------------
// instruction_memory_loader_pkg
// Constants and types shared by the instruction memory loader and the
// fetch-side memory reader.
//   load_state_t      : loader session states
//   MEM_BYTES_DEFAULT : default instruction memory size in bytes
//   BYTES_PER_INSTR   : bytes per instruction word
//   instr_byte()      : little-endian byte lane select from a 32-bit word
// ---------------------------------------------------------------------------
package instruction_memory_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    localparam int MEM_BYTES_DEFAULT = 1024;
    localparam int BYTES_PER_INSTR   = 4;

    // Byte idx of a word; byte 0 lives at the lowest address.
    function automatic logic [7:0] instr_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/instruction_memory_loader.sv
// ---------------------------------------------------------------------------
// instruction_memory_loader
// Accepts 32-bit instruction words from a valid/ready producer and writes
// them into a byte-wide instruction memory, one byte per cycle, starting at
// a word-aligned base address.
//
// Ports
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   start_i             : opens (or restarts) a load session at base_addr_i
//   base_addr_i         : session start byte address (must be word aligned)
//   word_valid_i/word_i : producer word and its valid
//   last_i              : marks the final word of the session
//   word_ready_o        : loader accepts word_i this cycle
//   mem_we_o/mem_addr_o/mem_wdata_o : byte write port to the memory
//   busy_o              : session open
//   done_o              : final word fully written (level)
//   load_error_o        : misaligned base or memory overrun (sticky)
//   word_count_o        : words fully written in the current session
// ---------------------------------------------------------------------------
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int ADDR_W    = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              word_valid_i,
    input  logic [31:0]       word_i,
    input  logic              last_i,
    output logic              word_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              load_error_o,
    output logic [ADDR_W-2:0] word_count_o
);

    // Pointer carries one extra bit so ptr+3 never wraps past the memory end.
    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);
    localparam logic [ADDR_W:0] WORD_SPAN = (ADDR_W+1)'(BYTES_PER_INSTR - 1);
    localparam logic [ADDR_W:0] WORD_STEP = (ADDR_W+1)'(BYTES_PER_INSTR);

    load_state_t       state_reg;
    logic [ADDR_W:0]   ptr_reg;
    logic [ADDR_W-2:0] count_reg;
    logic [31:0]       word_reg;
    logic              last_reg;
    logic [1:0]        idx_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_wdata_reg;

    logic [ADDR_W:0]   ptr_end;

    assign ptr_end = ptr_reg + WORD_SPAN;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            count_reg     <= '0;
            word_reg      <= '0;
            last_reg      <= 1'b0;
            idx_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (start_i) begin
            // A start in any state drops whatever word is in flight.
            mem_we_reg <= 1'b0;
            count_reg  <= '0;
            idx_reg    <= '0;
            if (base_addr_i[1:0] != 2'b00) begin
                state_reg <= ST_ERROR;
            end else begin
                state_reg <= ST_ACCEPT;
                ptr_reg   <= {1'b0, base_addr_i};
            end
        end else begin
            case (state_reg)
                ST_ACCEPT: begin
                    if (word_valid_i) begin
                        if (ptr_end > LAST_BYTE) begin
                            // Word is consumed but would run off the memory.
                            state_reg <= ST_ERROR;
                        end else begin
                            state_reg     <= ST_WRITE;
                            word_reg      <= word_i;
                            last_reg      <= last_i;
                            idx_reg       <= '0;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= ptr_reg[ADDR_W-1:0];
                            mem_wdata_reg <= word_i[7:0];
                        end
                    end
                end
                ST_WRITE: begin
                    if (idx_reg == 2'd3) begin
                        mem_we_reg <= 1'b0;
                        ptr_reg    <= ptr_reg + WORD_STEP;
                        count_reg  <= count_reg + (ADDR_W-1)'(1);
                        state_reg  <= last_reg ? ST_DONE : ST_ACCEPT;
                    end else begin
                        // Outputs are registered, so stage the next byte now.
                        idx_reg       <= idx_reg + 2'd1;
                        mem_addr_reg  <= ptr_reg[ADDR_W-1:0] + ADDR_W'(idx_reg + 2'd1);
                        mem_wdata_reg <= instr_byte(word_reg, idx_reg + 2'd1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign word_ready_o = (state_reg == ST_ACCEPT) && !start_i;
    assign mem_we_o     = mem_we_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;
    assign busy_o       = (state_reg == ST_ACCEPT) || (state_reg == ST_WRITE);
    assign done_o       = (state_reg == ST_DONE);
    // ERROR is only left through start_i, which makes the flag sticky.
    assign load_error_o = (state_reg == ST_ERROR);
    assign word_count_o = count_reg;

endmodule

// File: doc/instruction_memory_loader.md
INSTRUCTION_MEMORY_LOADER -- requirements
Module: instruction_memory_loader

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024, giving the instruction memory size in bytes.
REQ-002 The block SHALL have parameter ADDR_W, default 10, giving the byte address width, with MEM_BYTES <= 2**ADDR_W.
REQ-003 clk_i  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n_i  input  1  reset; asynchronous and active-low.
REQ-005 start_i  input  1  single-cycle pulse that opens a load session at base_addr_i.
REQ-006 base_addr_i  input  ADDR_W  start byte address; sampled only when start_i=1.
REQ-007 word_valid_i  input  1  producer has an instruction word on word_i.
REQ-008 word_i  input  32  instruction word.
REQ-009 last_i  input  1  word_i is the final word of the session; qualified by word_valid_i.
REQ-010 word_ready_o  output  1  loader accepts word_i in this cycle.
REQ-011 mem_we_o  output  1  byte write strobe to the instruction memory.
REQ-012 mem_addr_o  output  ADDR_W  byte write address.
REQ-013 mem_wdata_o  output  8  byte write data.
REQ-014 busy_o  output  1  session open (ACCEPT or WRITE state).
REQ-015 done_o  output  1  level; last word fully written.
REQ-016 load_error_o  output  1  sticky error flag, cleared only by start_i or reset.
REQ-017 word_count_o  output  ADDR_W-1  number of words fully written in the current session.

Function
REQ-018 States: IDLE, ACCEPT, WRITE, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + start_i: base_addr_i[1:0]==0 -> ACCEPT with ptr=base_addr_i, count=0, done_o=0, load_error_o=0.
REQ-020 start_i with base_addr_i[1:0]!=0 -> ERROR, load_error_o=1 next cycle, no write.
REQ-021 start_i in ACCEPT or WRITE SHALL abort the session: in-flight bytes are dropped, then REQ-019/REQ-020 apply; bytes already written stay written.
REQ-022 word_ready_o SHALL be 1 only in ACCEPT with start_i=0; a transfer occurs when word_valid_i=1 and word_ready_o=1.
REQ-023 On transfer with ptr+3 <= MEM_BYTES-1: capture word_i and last_i, go to WRITE with byte index k=0.
REQ-024 On transfer with ptr+3 > MEM_BYTES-1: the word is consumed but not written, go to ERROR, load_error_o=1.
REQ-025 WRITE SHALL take exactly 4 cycles, k=0..3: mem_we_o=1, mem_addr_o=ptr+k, mem_wdata_o=word[8k+7:8k] (little-endian; byte 0 at lowest address).
REQ-026 After k=3: ptr+=4 and count+=1. If the captured last=1, go to DONE with done_o=1 and busy_o=0; otherwise return to ACCEPT.
REQ-027 Throughput SHALL be 1 word per 5 cycles with the producer always valid; latency from transfer to first write is 1 cycle.
REQ-028 mem_we_o SHALL be 0 in every state except WRITE.
REQ-029 word_valid_i SHALL be ignored outside ACCEPT.
REQ-030 ptr arithmetic SHALL be ADDR_W+1 bits so the overrun check in REQ-024 cannot wrap.

Reset
REQ-031 rst_n_i=0 SHALL asynchronously force IDLE, ptr=0, count=0, and all outputs 0, including mem_we_o.
REQ-032 Reset mid-WRITE SHALL stop writes within the same cycle, with no partial-word completion after release.
REQ-033 The first start_i SHALL be honored on the first clock edge after rst_n_i deasserts.

Structure
REQ-034 A shared package SHALL hold the state enum, MEM_BYTES_DEFAULT=1024 and BYTES_PER_INSTR=4; the fetch-side memory reader SHALL use the same constants.
REQ-035 The block SHALL be a single module with no sub-modules; the optional byte serializer (word register plus 2-bit index) stays inline.

Verification
REQ-036 Reset, start base=0, 3 words (0x00500093, 0x00108133, 0xcccccccc with last) back-to-back -> 12 writes at addr 0..11: bytes 93,00,50,00,33,81,10,00,cc x4; done_o=1; word_count_o=3; total 15 cycles from first transfer to DONE.
REQ-037 start base=0x3F8, 3 words -> writes at 0x3F8..0x3FF; third word consumed without write; load_error_o=1; state ERROR.
REQ-038 start base=0x002 -> no writes; load_error_o=1 the next cycle.
REQ-039 Producer valid toggles every other cycle -> byte order and addresses unchanged; word_ready_o is never 1 in WRITE.
REQ-040 start_i asserted during WRITE k=1 with base=0x100 -> no further writes to the old addresses; the next word is written at 0x100; count restarts at 0.
REQ-041 rst_n_i pulsed low mid-WRITE, asynchronous to clk_i -> mem_we_o drops immediately; all outputs are 0; a reload afterwards completes normally.
